// File: rtl/test_fifo.sv
// FIFO test wrapper: a 32-bit counter feeds a circular-buffer FIFO.
// Optional TEST_FIFO_OCCUPANCY_EN adds level/full outputs.
module test_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             try_push,
  input  logic             try_pop,
  output logic             push_success,
  output logic [WIDTH-1:0] push_v,
  output logic             pop_success,
`ifdef TEST_FIFO_OCCUPANCY_EN
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic             full,
`endif
  output logic [WIDTH-1:0] pop_v
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] CFULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] gen;

  // full/empty decided by count, never by pointer compare
  assign push_success = rst & try_push & (count != CFULL);
  assign pop_success  = rst & try_pop & (count != '0);
  assign push_v       = gen;
  assign pop_v        = mem[rd_ptr];

`ifdef TEST_FIFO_OCCUPANCY_EN
  assign level = count;
  assign full  = (count == CFULL);
`endif

  always_ff @(posedge clk) begin
    if (push_success) mem[wr_ptr] <= push_v;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      gen    <= '0;
    end else begin
      if (push_success) begin
        wr_ptr <= wr_ptr + 1'b1;
        gen    <= gen + 1'b1;
      end
      if (pop_success) rd_ptr <= rd_ptr + 1'b1;
      case ({push_success, pop_success})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_test_fifo.sv
// Directed bench for test_fifo: hand-computed vectors
// backed by a reference queue for ordering.
module tb_test_fifo;

  localparam int DEPTH = 16;
  localparam int WIDTH = 32;

  logic clk = 0;
  logic rst = 0;
  logic try_push = 0;
  logic try_pop = 0;
  logic push_success, pop_success;
  logic [WIDTH-1:0] push_v, pop_v;
`ifdef TEST_FIFO_OCCUPANCY_EN
  logic [$clog2(DEPTH+1)-1:0] level;
  logic full;
`endif

  test_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk),
    .rst(rst),
    .try_push(try_push),
    .try_pop(try_pop),
    .push_success(push_success),
    .push_v(push_v),
    .pop_success(pop_success),
`ifdef TEST_FIFO_OCCUPANCY_EN
    .level(level),
    .full(full),
`endif
    .pop_v(pop_v)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errs = 0;
  logic [31:0] mq[$];
  logic [31:0] mgen = 0;
  int n_push = 0;
  int n_pop = 0;
  logic last_ps, last_pp;
  logic [31:0] last_pushv, last_popv;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0d want %0d",
               tag, obs, exp);
    end
  endtask

  // drive one cycle, check outputs at negedge
  task automatic step(input logic p, input logic q);
    logic eps, epp;
    try_push = p;
    try_pop  = q;
    @(negedge clk);
    eps = rst && p && (mq.size() != DEPTH);
    epp = rst && q && (mq.size() != 0);
    chk("push_success", 32'(push_success), 32'(eps));
    chk("pop_success", 32'(pop_success), 32'(epp));
    if (!rst) chk("rst_push_v", push_v, 0);
    if (eps) chk("push_v", push_v, mgen);
    if (epp) chk("pop_v", pop_v, mq[0]);
`ifdef TEST_FIFO_OCCUPANCY_EN
    chk("level", 32'(level), 32'(mq.size()));
    chk("full", 32'(full), 32'(mq.size() == DEPTH));
`endif
    last_ps = push_success;
    last_pp = pop_success;
    last_pushv = push_v;
    last_popv = pop_v;
    if (push_success) n_push++;
    if (pop_success) n_pop++;
    if (epp) void'(mq.pop_front());
    if (eps) begin
      mq.push_back(mgen);
      mgen++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc;
    logic [31:0] prev;
    // reset held with requests high
    repeat (5) step(1, 1);
    rst = 1;
    repeat (5) begin
      step(0, 1);
      chk("empty_pop", 32'(last_pp), 0);
    end
    // trickle
    for (int i = 0; i < 10; i++) begin
      step(1, 0);
      chk("trickle_v", last_pushv, i);
      step(0, 0);
      step(0, 0);
    end
    // flood to full: 6 more accepted
    acc = 0;
    repeat (12) begin
      step(1, 0);
      if (last_ps) acc++;
    end
    chk("flood_cnt", acc, 6);
    chk("full_push_v", push_v, 16);
    // drain
    for (int i = 0; i < 16; i++) begin
      step(0, 1);
      chk("drain_v", last_popv, i);
    end
    step(0, 1);
    chk("drained", 32'(last_pp), 0);
    // refill, then pop one every 10 cycles
    repeat (16) step(1, 0);
    for (int k = 0; k < 30; k++) begin
      step(1, 1);
      chk("pop_cyc_push", 32'(last_ps), 0);
      chk("pop_cyc_pop", 32'(last_pp), 1);
      chk("pop_cyc_v", last_popv, 16 + k);
      step(1, 0);
      chk("refill_push", 32'(last_ps), 1);
      chk("refill_v", last_pushv, 32 + k);
      repeat (8) step(1, 0);
    end
    // half-drain then steady
    repeat (8) step(0, 1);
    prev = mq[0] - 1;
    for (int k = 0; k < 100; k++) begin
      step(1, 1);
      if (k % 10 == 0) begin
        chk("steady_both",
            32'({last_ps, last_pp}), 3);
        chk("steady_inc", last_popv, prev + 1);
      end
      prev = last_popv;
    end
    // random, then drain
    for (int k = 0; k < 200; k++)
      step(1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)));
    for (int k = 0; k < DEPTH + 2; k++)
      step(0, 1);
    chk("final_pop", 32'(last_pp), 0);
    chk("push_eq_pop", n_push, n_pop);
    // mid-stream reset with 7 entries
    repeat (7) step(1, 0);
    #2 rst = 0;
    mq.delete();
    mgen = 0;
    step(0, 1);
    chk("rst_pop", 32'(last_pp), 0);
    rst = 1;
    step(1, 0);
    chk("post_rst_v", last_pushv, 0);
    step(0, 1);
    chk("post_rst_pop", last_popv, 0);
    step(0, 1);
    chk("post_rst_empty", 32'(last_pp), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got 1 want 0");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/test_fifo.md
Name: test_fifo

Overview:
- Self-contained FIFO test wrapper: an internal 32-bit sequence generator feeds a synchronous circular-buffer FIFO.
- The bench issues only push/pop requests; the block reports which requests succeeded and the data moved on each side.
- Used as a DUT for FIFO ordering/scoreboard checks; no external data input.

Parameters:
- DEPTH, 16, number of FIFO entries (power of two, >=2).
- WIDTH, 32, data width of push_v/pop_v and of the generator.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- try_push  input  1  request to push the current generator value this cycle.
- try_pop  input  1  request to pop the head entry this cycle.
- push_success  output  1  push accepted this cycle (combinational).
- push_v  output  WIDTH  value being pushed this cycle (generator value); valid when push_success=1.
- pop_success  output  1  pop accepted this cycle (combinational).
- pop_v  output  WIDTH  head entry; valid when pop_success=1.

Behaviour:
- Reset (rst=0, asynchronous): wr_ptr=0, rd_ptr=0, count=0, generator=0. While reset is held: push_success=0, pop_success=0, push_v=0. pop_v is don't-care.
- Reset mid-operation discards all contents immediately; the first push after release carries value 0.
- push_success = rst & try_push & (count != DEPTH). No push is accepted when full, even if a pop succeeds in the same cycle.
- pop_success = rst & try_pop & (count != 0). No same-cycle bypass: a push into an empty FIFO is not poppable until the next cycle.
- push_v = generator register, always driven.
- On push_success: mem[wr_ptr] <= push_v; wr_ptr++ (wraps modulo DEPTH); generator++ (wraps modulo 2^WIDTH).
- pop_v = mem[rd_ptr], combinational read. On pop_success: rd_ptr++ (wraps modulo DEPTH).
- count update: +1 on push only, -1 on pop only, unchanged on both or neither. count is never allowed outside 0..DEPTH.
- Success outputs are asserted only when the corresponding try input is high in the same cycle.
- Ordering: pop_v values appear in exactly the order pushed, i.e. consecutive integers 0, 1, 2, ... with no gaps or duplicates.
- Latency: an entry written at edge N is visible on pop_v from cycle N+1.
- Both-full-and-empty ambiguity is resolved by count, not by pointer comparison.

Optional Feature:
- TEST_FIFO_OCCUPANCY_EN
  - Defined: adds output port level [$clog2(DEPTH+1)-1:0] driving count directly (0 during reset), plus output full = (count==DEPTH).
  - Undefined: neither port exists; functional behaviour is otherwise identical.

Test Plan:
- Reset 5 cycles, release, try_pop=1 for 5 cycles on empty FIFO -> pop_success=0 every cycle.
- Trickle: 10 single-cycle pushes separated by 2 idle cycles -> push_v=0..9, each push_success=1; count=10.
- Flood push with no pops -> push_success stays 1 until count=16 (next push_v=16), then 0 every cycle; stall >5 cycles. Drain -> pop_v=0..15 in order, then pop_success=0.
- Full FIFO, push held, 1-cycle pop every 10 cycles, 30 times -> each pop frees one slot; exactly one push accepted the following cycle; no push accepted in the pop cycle itself; order preserved.
- Steady try_push=try_pop=1 for 100 cycles from a non-empty, non-full state -> both succeed every cycle; count constant; pop_v strictly increments by 1.
- Random try_push/try_pop for 200 cycles, then drain -> every pop_v matches the reference queue; final count=0; pops equal pushes.
- Assert rst=0 mid-stream with count=7 -> pop_success=0 next cycle; first push after release has push_v=0.
